// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi
//   Multi-channel level-to-pulse generator. Each channel optionally
//   synchronises its level input, detects a selectable edge, and emits a
//   registered pulse PULSE_LEN clocks wide. BUSY is the registered OR of
//   all pulse outputs.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   LVL_SIG    [CH]     level inputs, one bit per channel
//   EDGE_SEL   [2*CH]   per-channel mode, bits [2i+1:2i]:
//                       00 rise, 01 fall, 10 both, 11 disabled
//   PULSE_SIG  [CH]     registered pulse outputs
//   BUSY                registered OR of PULSE_SIG (lags it by one clock)
//
// There is no handshake on this block: inputs are levels, outputs are
// strobes, and every output comes straight from a flop.

module pulse_gen_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 0,
    parameter int PULSE_LEN   = 1,
    parameter int RETRIGGER   = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   LVL_SIG,
    input  logic [2*CH-1:0] EDGE_SEL,
    output logic [CH-1:0]   PULSE_SIG,
    output logic            BUSY
);

    localparam int            CW     = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CH-1:0] sync_out;
    logic [CH-1:0] s_cur;
    logic [CH-1:0] s_prev;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] det;
    logic [CW-1:0] cnt [CH];

    // Optional synchroniser chain; with zero stages the input is taken as
    // already synchronous and feeds s_cur directly.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_out = LVL_SIG;
        end else begin : g_sync
            logic [CH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= LVL_SIG;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // History pair. Clearing to zero means a level already high at reset
    // release reads as a rising edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_cur  <= '0;
            s_prev <= '0;
        end else begin
            s_cur  <= sync_out;
            s_prev <= s_cur;
        end
    end

    assign rise = s_cur & ~s_prev;
    assign fall = ~s_cur & s_prev;

    always_comb begin
        det = '0;
        for (int i = 0; i < CH; i++) begin
            case (EDGE_SEL[2*i +: 2])
                2'b00:   det[i] = rise[i];
                2'b01:   det[i] = fall[i];
                2'b10:   det[i] = rise[i] | fall[i];
                default: det[i] = 1'b0;
            endcase
        end
    end

    // Width counters. cnt holds the number of further cycles the pulse
    // stays high after the current one. Without retrigger an edge is only
    // accepted while the output is low, so an edge on the final pulse cycle
    // (cnt already 0, output still 1) is dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PULSE_SIG <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (det[i] && (!PULSE_SIG[i] || (RETRIGGER != 0))) begin
                    PULSE_SIG[i] <= 1'b1;
                    cnt[i]       <= RELOAD;
                end else if (cnt[i] != '0) begin
                    PULSE_SIG[i] <= 1'b1;
                    cnt[i]       <= cnt[i] - ONE;
                end else begin
                    PULSE_SIG[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            BUSY <= 1'b0;
        end else begin
            BUSY <= |PULSE_SIG;
        end
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi
//   Directed bench for pulse_gen_multi. Five instances cover the
//   parameter sets of interest:
//     u_a : CH=4, SYNC=0, LEN=1, RETRIGGER=1  (reset release, rise, both, disable, channels)
//     u_b : CH=1, SYNC=0, LEN=3, RETRIGGER=1  (retrigger extends)
//     u_c : CH=1, SYNC=0, LEN=3, RETRIGGER=0  (retrigger ignored)
//     u_d : CH=1, SYNC=2, LEN=1               (synchroniser latency)
//     u_e : CH=1, SYNC=0, LEN=4               (asynchronous reset mid-pulse)
//   Inputs change 2 ns after a rising edge; outputs are sampled 2 ns after
//   the following rising edge. Expected words are {busy, pulse}.

module tb_pulse_gen_multi;

    logic       CLK;
    logic       rst_n;
    logic       rst_e;

    logic [3:0] lvl_a;
    logic [7:0] edge_a;
    logic [3:0] pulse_a;
    logic       busy_a;

    logic       lvl_bc;
    logic [1:0] edge_bc;
    logic       pulse_b, busy_b;
    logic       pulse_c, busy_c;

    logic       lvl_d;
    logic [1:0] edge_d;
    logic       pulse_d, busy_d;

    logic       lvl_e;
    logic [1:0] edge_e;
    logic       pulse_e, busy_e;

    int         n_tests;
    int         n_fail;
    int         step_no;

    logic [7:0] exp_q[$];

    pulse_gen_multi #(.CH(4), .SYNC_STAGES(0), .PULSE_LEN(1), .RETRIGGER(1)) u_a (
        .CLK(CLK), .RST(rst_n), .LVL_SIG(lvl_a), .EDGE_SEL(edge_a),
        .PULSE_SIG(pulse_a), .BUSY(busy_a));

    pulse_gen_multi #(.CH(1), .SYNC_STAGES(0), .PULSE_LEN(3), .RETRIGGER(1)) u_b (
        .CLK(CLK), .RST(rst_n), .LVL_SIG(lvl_bc), .EDGE_SEL(edge_bc),
        .PULSE_SIG(pulse_b), .BUSY(busy_b));

    pulse_gen_multi #(.CH(1), .SYNC_STAGES(0), .PULSE_LEN(3), .RETRIGGER(0)) u_c (
        .CLK(CLK), .RST(rst_n), .LVL_SIG(lvl_bc), .EDGE_SEL(edge_bc),
        .PULSE_SIG(pulse_c), .BUSY(busy_c));

    pulse_gen_multi #(.CH(1), .SYNC_STAGES(2), .PULSE_LEN(1), .RETRIGGER(1)) u_d (
        .CLK(CLK), .RST(rst_n), .LVL_SIG(lvl_d), .EDGE_SEL(edge_d),
        .PULSE_SIG(pulse_d), .BUSY(busy_d));

    pulse_gen_multi #(.CH(1), .SYNC_STAGES(0), .PULSE_LEN(4), .RETRIGGER(1)) u_e (
        .CLK(CLK), .RST(rst_e), .LVL_SIG(lvl_e), .EDGE_SEL(edge_e),
        .PULSE_SIG(pulse_e), .BUSY(busy_e));

    // ---------------- clock / watchdog ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
        step_no++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    // Drive u_a, push the expectation for the edge that follows, then pop
    // and compare once that edge has produced its output.
    task automatic step_a(input logic [3:0] lvl, input logic [3:0] ep, input logic eb);
        lvl_a = lvl;
        exp_q.push_back({3'b000, eb, ep});
        tick();
        check("a", {3'b000, busy_a, pulse_a}, exp_q.pop_front());
    endtask

    task automatic step_bc(input logic lvl, input logic pb, input logic bb,
                           input logic pc, input logic bc);
        lvl_bc = lvl;
        exp_q.push_back({6'b0, bb, pb});
        exp_q.push_back({6'b0, bc, pc});
        tick();
        check("b_retrig", {6'b0, busy_b, pulse_b}, exp_q.pop_front());
        check("c_noretrig", {6'b0, busy_c, pulse_c}, exp_q.pop_front());
    endtask

    task automatic step_d(input logic lvl, input logic pd, input logic bd);
        lvl_d = lvl;
        exp_q.push_back({6'b0, bd, pd});
        tick();
        check("d_sync", {6'b0, busy_d, pulse_d}, exp_q.pop_front());
    endtask

    task automatic step_e(input logic lvl, input logic pe, input logic be);
        lvl_e = lvl;
        exp_q.push_back({6'b0, be, pe});
        tick();
        check("e_rst", {6'b0, busy_e, pulse_e}, exp_q.pop_front());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        step_no = 0;
        rst_n   = 1'b0;
        rst_e   = 1'b0;
        lvl_a   = 4'b0001;
        edge_a  = 8'h00;
        lvl_bc  = 1'b0;
        edge_bc = 2'b00;
        lvl_d   = 1'b0;
        edge_d  = 2'b00;
        lvl_e   = 1'b0;
        edge_e  = 2'b00;

        // Reset state, with u_a's channel 0 already high.
        tick();
        tick();
        check("reset_a", {3'b000, busy_a, pulse_a}, 8'h00);
        check("reset_b", {6'b0, busy_b, pulse_b}, 8'h00);
        check("reset_c", {6'b0, busy_c, pulse_c}, 8'h00);
        check("reset_d", {6'b0, busy_d, pulse_d}, 8'h00);
        check("reset_e", {6'b0, busy_e, pulse_e}, 8'h00);
        rst_n = 1'b1;
        rst_e = 1'b1;

        // 1: level held high through release reads as one rising edge.
        step_a(4'b0001, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0001, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b1);
        step_a(4'b0001, 4'b0000, 1'b0);

        // 2: high 3, low 1, high again -> two pulses four cycles apart,
        //    nothing on the fall.
        step_a(4'b0000, 4'b0000, 1'b0);
        step_a(4'b0000, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0001, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b1);
        step_a(4'b0000, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0001, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b1);
        step_a(4'b0001, 4'b0000, 1'b0);

        // 3: both-edge mode, toggle every 5 cycles -> pulse per toggle.
        edge_a = 8'b00_00_00_10;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                step_a({3'b000, k[0]}, {3'b000, (c == 1)}, (c == 2));
            end
        end
        // Disabled: toggles produce nothing.
        edge_a = 8'b00_00_00_11;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 5; c++) begin
                step_a({3'b000, k[0]}, 4'b0000, 1'b0);
            end
        end

        // Channel independence: ch3 disabled, ch2 fall, ch1 rise, ch0 disabled.
        edge_a = 8'b11_01_00_11;
        step_a(4'b1111, 4'b0000, 1'b0);
        step_a(4'b1111, 4'b0010, 1'b0);
        step_a(4'b1111, 4'b0000, 1'b1);
        step_a(4'b1111, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b0);
        step_a(4'b0001, 4'b0100, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b1);
        step_a(4'b0001, 4'b0000, 1'b0);
        // Simultaneous edges on ch1 and ch2 both pulse.
        edge_a = 8'b11_10_10_11;
        step_a(4'b0111, 4'b0000, 1'b0);
        step_a(4'b0111, 4'b0110, 1'b0);
        step_a(4'b0111, 4'b0000, 1'b1);
        step_a(4'b0111, 4'b0000, 1'b0);

        // 4: LEN=3, rise, 1-cycle low, rise again.
        //    Retrigger: 5 cycles high. No retrigger: 3 cycles high.
        step_bc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step_bc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step_bc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step_bc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step_bc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step_bc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Edge detected on the last pulse cycle: dropped without retrigger,
        // extends the pulse with retrigger.
        step_bc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step_bc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step_bc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step_bc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step_bc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step_bc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step_bc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: two synchroniser stages -> pulse at sampling edge n+3.
        step_d(1'b1, 1'b0, 1'b0);
        step_d(1'b1, 1'b0, 1'b0);
        step_d(1'b1, 1'b0, 1'b0);
        step_d(1'b1, 1'b1, 1'b0);
        step_d(1'b1, 1'b0, 1'b1);
        step_d(1'b1, 1'b0, 1'b0);

        // 6: LEN=4, reset asserted in the second pulse cycle.
        step_e(1'b1, 1'b0, 1'b0);
        step_e(1'b1, 1'b1, 1'b0);
        step_e(1'b1, 1'b1, 1'b1);
        rst_e = 1'b0;
        #1;
        check("e_async_clear", {6'b0, busy_e, pulse_e}, 8'h00);
        tick();
        check("e_held_reset", {6'b0, busy_e, pulse_e}, 8'h00);
        rst_e = 1'b1;
        // History was cleared, so the still-high input is seen as a fresh
        // rising edge: exactly one full-width pulse, no resumed pulse.
        step_e(1'b1, 1'b0, 1'b0);
        step_e(1'b1, 1'b1, 1'b0);
        step_e(1'b1, 1'b1, 1'b1);
        step_e(1'b1, 1'b1, 1'b1);
        step_e(1'b1, 1'b1, 1'b1);
        step_e(1'b1, 1'b0, 1'b1);
        step_e(1'b1, 1'b0, 1'b0);
        step_e(1'b0, 1'b0, 1'b0);
        step_e(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
